// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the program counter and the
//                IF/ID pipeline register, applies hazard-unit stall/flush
//                requests and branch/jump redirects, and keeps two
//                saturating event counters (stall cycles, flush cycles).
//  Ports       : clk_i, rst_i            clock, sync active-high reset
//                pc_write_i             1 = PC advances, 0 = PC holds
//                if2id_write_i          1 = IF/ID captures a new fetch
//                if2id_flush_i          1 = IF/ID loads a bubble
//                redirect_i,
//                redirect_pc_i          taken branch/jump and its target
//                imem_addr_o            instruction address (= PC register)
//                imem_instr_i           instruction at imem_addr_o
//                id_instr_o, id_pc4_o,
//                id_valid_o             IF/ID register contents
//                stall_cnt_o,
//                flush_cnt_o            saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_write_i,
    input  logic             if2id_write_i,
    input  logic             if2id_flush_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      id_instr_o,
    output logic [31:0]      id_pc4_o,
    output logic             id_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [31:0]      r_pc;
    logic [31:0]      r_id_instr;
    logic [31:0]      r_id_pc4;
    logic             r_id_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [31:0]      w_pc4;
    logic [31:0]      w_redirect_pc;
    logic             w_stall_evt;
    logic             w_unused_bits;

    // PC+4 wraps naturally modulo 2^32.
    assign w_pc4         = r_pc + 32'd4;
    // Targets are forced word-aligned; the low bits are dropped.
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_bits = ^redirect_pc_i[1:0];
    // A redirect cancels the stall, so it does not count as a stall cycle.
    assign w_stall_evt   = !redirect_i && !pc_write_i;

    // Program counter: reset > redirect > hold > advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= w_redirect_pc;
        end else if (pc_write_i) begin
            r_pc <= w_pc4;
        end
    end

    // IF/ID register: reset/flush (bubble) > capture > hold.
    always_ff @(posedge clk_i) begin
        if (rst_i || if2id_flush_i) begin
            r_id_instr <= 32'h0000_0000;
            r_id_pc4   <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (if2id_write_i) begin
            r_id_instr <= imem_instr_i;
            r_id_pc4   <= w_pc4;
            r_id_valid <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (if2id_flush_i && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign imem_addr_o = r_pc;
    assign id_instr_o  = r_id_instr;
    assign id_pc4_o    = r_id_pc4;
    assign id_valid_o  = r_id_valid;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire
